fs_scan_ctrl: RTL and testbench
===============================

Name: fs_scan_ctrl

Overview:
- Frame-level sequencer for the FAST-9 feature-score pipeline.
- Walks the reference-pixel address in raster order over the valid interior of the image, excluding the circle-radius border.
- Per pixel: handshakes with the pixel-fetch unit for the centre and 16 circle pixels, then issues one evaluate cycle to the score datapath/score memory.
- Counts detected corners and signals frame completion.

Parameters:
- IMG_W, 160, image width in pixels
- IMG_H, 120, image height in pixels
- BORDER, 3, skipped rows/columns on each edge (FAST-9 circle radius)
- ADDR_W, 15, pixel/score address width; IMG_W*IMG_H must be <= 2^ADDR_W

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin frame scan; sampled in IDLE only
- abort  in  1  terminate scan; return to IDLE without done
- thres_in  in  8  threshold, latched on accepted start
- fetch_req  out  1  request pixel set at fetch_addr
- fetch_addr  out  ADDR_W  centre-pixel address for the fetch unit
- fetch_ack  in  1  pixel set valid at the fetch unit outputs this cycle
- is_corner  in  1  corner flag from the detector; sampled in EVAL
- eval  out  1  one-cycle strobe; datapath computes and writes the score this cycle
- ref_addr  out  ADDR_W  score-memory address, valid while eval=1
- thres  out  8  latched threshold to the datapath
- busy  out  1  high from accepted start until DONE or abort
- done  out  1  one-cycle pulse at frame completion
- corner_cnt  out  16  corners counted in the current/last frame

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; internal x/y/address counters 0.
- States: IDLE, FETCH, EVAL, DONE.
  - CLEAR is added only when FS_CLEAR_EN is defined.
- IDLE:
  - On start=1: latch thres_in, set corner_cnt=0, x=BORDER, y=BORDER, addr=BORDER*IMG_W+BORDER, busy=1.
  - Next state: FETCH.
- FETCH:
  - fetch_req=1 and fetch_addr=addr, both held stable until fetch_ack=1.
  - On ack: next state EVAL, and fetch_req drops in the same edge.
  - Wait on ack is unbounded.
- EVAL:
  - eval=1 for exactly one cycle; ref_addr=addr.
  - If is_corner=1, corner_cnt increments by 1, saturating at 16'hFFFF.
  - Advance:
    - If x < IMG_W-1-BORDER: x+1, addr+1.
    - Otherwise: x=BORDER, y+1, addr += 2*BORDER+1.
  - If the evaluated pixel was the last one (x=IMG_W-1-BORDER and y=IMG_H-1-BORDER), next state is DONE; otherwise FETCH.
- DONE: done=1 for one cycle, busy=0, then IDLE. corner_cnt holds until the next accepted start.
- Minimum throughput: 2 cycles per pixel (fetch_ack on the first FETCH cycle).
- Address arithmetic is ADDR_W bits unsigned; no wrap occurs for legal parameters.
- Boundary conditions:
  - start while busy: ignored.
  - fetch_ack outside FETCH: ignored.
  - is_corner outside EVAL: ignored.
  - abort=1 in any non-IDLE state: next state IDLE, busy=0, no done, no eval. corner_cnt keeps its partial value.
  - abort and start in the same cycle in IDLE: start wins.
  - Asynchronous reset mid-scan: immediate return to reset values. Any pending fetch_req is dropped; the fetch unit must tolerate this.
  - Degenerate region (IMG_W or IMG_H <= 2*BORDER): start goes directly to DONE, with a done pulse and corner_cnt=0.

Optional Feature:
- FS_CLEAR_EN defined:
  - Adds ports clr_wren (out 1) and clr_addr (out ADDR_W).
  - An accepted start first enters CLEAR. For IMG_W*IMG_H cycles, clr_wren=1 with clr_addr = 0,1,...,IMG_W*IMG_H-1; the score data input is forced to 0 by the datapath mux while clr_wren=1.
  - After the last address the FSM enters FETCH.
  - abort in CLEAR returns to IDLE.
- FS_CLEAR_EN undefined: no CLEAR state and no clr_* ports; start goes straight to FETCH. Border scores are whatever the memory previously held.

Test Plan:
- IMG_W=8, IMG_H=8, BORDER=3; start, fetch_ack tied 1, is_corner=0:
  - eval pulses with ref_addr 27, 28, 35, 36 on alternate cycles.
  - done pulses 1 cycle after the last eval; corner_cnt=0; busy high throughout.
- Same setup, is_corner=1 on evals 2 and 4 -> corner_cnt=2 at done.
- Same setup, fetch_ack delayed 3 cycles per pixel:
  - fetch_req stays high with fetch_addr stable (27, then 28, ...) until ack.
  - Exactly one eval per pixel.
- thres_in=0x14 at start, changed to 0x50 mid-scan -> thres stays 0x14 for the whole frame.
- abort asserted during FETCH of addr 35 -> IDLE next cycle; busy=0, no done, corner_cnt retains value. A new start rescans from addr 27.
- FS_CLEAR_EN, 8x8 -> 64 consecutive clr_wren cycles (addr 0..63) precede the first fetch_req, which targets addr 27.

Source files
------------

// File: rtl/fs_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fs_scan_ctrl
//  Function : Frame-level sequencer for the FAST-9 feature-score pipeline.
//             Walks the centre-pixel address in raster order over the image
//             interior (BORDER pixels skipped on every edge), handshakes
//             with the pixel-fetch unit, strobes one evaluate cycle per
//             pixel, counts corners and signals frame completion.
//  Options  : define FS_CLEAR_EN to add a score-memory clear pass
//             (clr_wren / clr_addr) ahead of the scan.
//  Revision : 1.0  initial release
// ============================================================================
module fs_scan_ctrl #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int BORDER = 3,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        thres_in,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    input  logic              is_corner,
    output logic              eval,
    output logic [ADDR_W-1:0] ref_addr,
    output logic [7:0]        thres,
    output logic              busy,
    output logic              done,
    output logic [15:0]       corner_cnt
`ifdef FS_CLEAR_EN
    ,
    output logic              clr_wren,
    output logic [ADDR_W-1:0] clr_addr
`endif
);

    // Scan-region geometry, all in ADDR_W-bit unsigned arithmetic
    localparam logic [ADDR_W-1:0] c_x_first    = ADDR_W'(BORDER);
    localparam logic [ADDR_W-1:0] c_x_last     = ADDR_W'(IMG_W - 1 - BORDER);
    localparam logic [ADDR_W-1:0] c_y_first    = ADDR_W'(BORDER);
    localparam logic [ADDR_W-1:0] c_y_last     = ADDR_W'(IMG_H - 1 - BORDER);
    localparam logic [ADDR_W-1:0] c_addr_first = ADDR_W'(BORDER * IMG_W + BORDER);
    // Jump from the last interior pixel of a row to the first of the next
    localparam logic [ADDR_W-1:0] c_row_step   = ADDR_W'(2 * BORDER + 1);
    // No interior pixels at all: a start completes immediately
    localparam bit                c_degenerate = (IMG_W <= 2 * BORDER) || (IMG_H <= 2 * BORDER);
`ifdef FS_CLEAR_EN
    localparam logic [ADDR_W-1:0] c_clr_last   = ADDR_W'(IMG_W * IMG_H - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EVAL  = 3'd2,
        S_DONE  = 3'd3
`ifdef FS_CLEAR_EN
        ,
        S_CLEAR = 3'd4
`endif
    } state_t;

    state_t              r_state_q,     w_state_d;
    logic [ADDR_W-1:0]   r_x_q,         w_x_d;
    logic [ADDR_W-1:0]   r_y_q,         w_y_d;
    logic [ADDR_W-1:0]   r_addr_q,      w_addr_d;
    logic [7:0]          r_thres_q,     w_thres_d;
    logic [15:0]         r_cnt_q,       w_cnt_d;
    logic                r_fetch_req_q, w_fetch_req_d;
    logic                r_eval_q,      w_eval_d;
    logic                r_busy_q,      w_busy_d;
    logic                r_done_q,      w_done_d;
`ifdef FS_CLEAR_EN
    logic                r_clr_wren_q,  w_clr_wren_d;
    logic [ADDR_W-1:0]   r_clr_addr_q,  w_clr_addr_d;
`endif

    // Next-state and next-output logic; the strobes are computed one cycle
    // ahead so every output comes straight from a flop.
    always_comb begin
        w_state_d     = r_state_q;
        w_x_d         = r_x_q;
        w_y_d         = r_y_q;
        w_addr_d      = r_addr_q;
        w_thres_d     = r_thres_q;
        w_cnt_d       = r_cnt_q;
        w_fetch_req_d = 1'b0;
        w_eval_d      = 1'b0;
        w_busy_d      = r_busy_q;
        w_done_d      = 1'b0;
`ifdef FS_CLEAR_EN
        w_clr_wren_d  = 1'b0;
        w_clr_addr_d  = r_clr_addr_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                // start outranks abort here: abort has nothing to stop
                if (start) begin
                    w_thres_d = thres_in;
                    w_cnt_d   = 16'd0;
                    w_x_d     = c_x_first;
                    w_y_d     = c_y_first;
                    w_addr_d  = c_addr_first;
                    if (c_degenerate) begin
                        w_state_d = S_DONE;
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                    end else begin
                        w_busy_d  = 1'b1;
`ifdef FS_CLEAR_EN
                        w_state_d    = S_CLEAR;
                        w_clr_wren_d = 1'b1;
                        w_clr_addr_d = '0;
`else
                        w_state_d     = S_FETCH;
                        w_fetch_req_d = 1'b1;
`endif
                    end
                end
            end
`ifdef FS_CLEAR_EN
            S_CLEAR: begin
                if (abort) begin
                    w_state_d = S_IDLE;
                    w_busy_d  = 1'b0;
                end else if (r_clr_addr_q == c_clr_last) begin
                    w_state_d     = S_FETCH;
                    w_fetch_req_d = 1'b1;
                end else begin
                    w_clr_wren_d = 1'b1;
                    w_clr_addr_d = r_clr_addr_q + ADDR_W'(1);
                end
            end
`endif
            S_FETCH: begin
                if (abort) begin
                    w_state_d = S_IDLE;
                    w_busy_d  = 1'b0;
                end else if (fetch_ack) begin
                    w_state_d = S_EVAL;
                    w_eval_d  = 1'b1;
                end else begin
                    w_fetch_req_d = 1'b1;
                end
            end
            S_EVAL: begin
                // An abort here discards the pixel: no count, no advance
                if (abort) begin
                    w_state_d = S_IDLE;
                    w_busy_d  = 1'b0;
                end else begin
                    if (is_corner && (r_cnt_q != 16'hFFFF)) begin
                        w_cnt_d = r_cnt_q + 16'd1;
                    end
                    if (r_x_q != c_x_last) begin
                        w_x_d         = r_x_q + ADDR_W'(1);
                        w_addr_d      = r_addr_q + ADDR_W'(1);
                        w_state_d     = S_FETCH;
                        w_fetch_req_d = 1'b1;
                    end else if (r_y_q != c_y_last) begin
                        w_x_d         = c_x_first;
                        w_y_d         = r_y_q + ADDR_W'(1);
                        w_addr_d      = r_addr_q + c_row_step;
                        w_state_d     = S_FETCH;
                        w_fetch_req_d = 1'b1;
                    end else begin
                        w_state_d = S_DONE;
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
            default: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately by the async reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q     <= S_IDLE;
            r_x_q         <= '0;
            r_y_q         <= '0;
            r_addr_q      <= '0;
            r_thres_q     <= 8'd0;
            r_cnt_q       <= 16'd0;
            r_fetch_req_q <= 1'b0;
            r_eval_q      <= 1'b0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
`ifdef FS_CLEAR_EN
            r_clr_wren_q  <= 1'b0;
            r_clr_addr_q  <= '0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_x_q         <= w_x_d;
            r_y_q         <= w_y_d;
            r_addr_q      <= w_addr_d;
            r_thres_q     <= w_thres_d;
            r_cnt_q       <= w_cnt_d;
            r_fetch_req_q <= w_fetch_req_d;
            r_eval_q      <= w_eval_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
`ifdef FS_CLEAR_EN
            r_clr_wren_q  <= w_clr_wren_d;
            r_clr_addr_q  <= w_clr_addr_d;
`endif
        end
    end

    // The address only moves when leaving EVAL, so it is stable for the
    // whole fetch handshake and for the evaluate strobe.
    assign fetch_req  = r_fetch_req_q;
    assign fetch_addr = r_addr_q;
    assign eval       = r_eval_q;
    assign ref_addr   = r_addr_q;
    assign thres      = r_thres_q;
    assign busy       = r_busy_q;
    assign done       = r_done_q;
    assign corner_cnt = r_cnt_q;
`ifdef FS_CLEAR_EN
    assign clr_wren   = r_clr_wren_q;
    assign clr_addr   = r_clr_addr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fs_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fs_scan_ctrl
//  Function : Self-checking bench for fs_scan_ctrl on an 8x8 image (BORDER 3)
//             plus a degenerate 6x8 instance. Expected pixel order comes from
//             a raster-order list built from the image geometry.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fs_scan_ctrl;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int B  = 3;
    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [7:0]    thres_in;
    logic          fetch_ack;
    logic          is_corner;

    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          eval;
    logic [AW-1:0] ref_addr;
    logic [7:0]    thres;
    logic          busy;
    logic          done;
    logic [15:0]   corner_cnt;

    logic          d_fetch_req;
    logic [AW-1:0] d_fetch_addr;
    logic          d_eval;
    logic [AW-1:0] d_ref_addr;
    logic [7:0]    d_thres;
    logic          d_busy;
    logic          d_done;
    logic [15:0]   d_corner_cnt;
`ifdef FS_CLEAR_EN
    logic          clr_wren;
    logic [AW-1:0] clr_addr;
    logic          d_clr_wren;
    logic [AW-1:0] d_clr_addr;
`endif

    int checks = 0;
    int errors = 0;
    int exp_addr[$];

    fs_scan_ctrl #(.IMG_W(W), .IMG_H(H), .BORDER(B), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .thres_in(thres_in), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .is_corner(is_corner), .eval(eval),
        .ref_addr(ref_addr), .thres(thres), .busy(busy), .done(done),
        .corner_cnt(corner_cnt)
`ifdef FS_CLEAR_EN
        , .clr_wren(clr_wren), .clr_addr(clr_addr)
`endif
    );

    fs_scan_ctrl #(.IMG_W(6), .IMG_H(8), .BORDER(B), .ADDR_W(AW)) dut_d (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .thres_in(thres_in), .fetch_req(d_fetch_req), .fetch_addr(d_fetch_addr),
        .fetch_ack(fetch_ack), .is_corner(is_corner), .eval(d_eval),
        .ref_addr(d_ref_addr), .thres(d_thres), .busy(d_busy), .done(d_done),
        .corner_cnt(d_corner_cnt)
`ifdef FS_CLEAR_EN
        , .clr_wren(d_clr_wren), .clr_addr(d_clr_addr)
`endif
    );

    always #5 clock = ~clock;

    // Interior pixels in raster order
    function automatic void build_model();
        exp_addr.delete();
        for (int y = B; y <= H - 1 - B; y++)
            for (int x = B; x <= W - 1 - B; x++)
                exp_addr.push_back(y * W + x);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic skip_clear();
`ifdef FS_CLEAR_EN
        for (int k = 0; k < W * H; k++) begin
            checks++;
            if ({clr_wren, clr_addr, fetch_req} !== {1'b1, AW'(k), 1'b0}) begin
                errors++;
                $display("FAIL clear[%0d]: wren=%b addr=%0d req=%b, required wren=1 addr=%0d req=0",
                         k, clr_wren, clr_addr, fetch_req, k);
            end
            step();
        end
`endif
    endtask

    // One full frame. cmode: 0 no corners, 1 corners on evals 2 and 4, 2 random.
    // rnd_ctl scatters start/thres_in/fetch_ack/is_corner where they must be ignored.
    task automatic run_frame(input logic [7:0] t, input int max_delay, input int cmode, input bit rnd_ctl);
        int cnt;
        int d;
        logic c;
        thres_in = t;
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        thres_in = 8'h50;
        skip_clear();
        cnt = 0;
        foreach (exp_addr[i]) begin
            d = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
            for (int k = 0; k <= d; k++) begin
                checks++;
                if ({fetch_req, fetch_addr, eval, busy, done} !== {1'b1, AW'(exp_addr[i]), 1'b0, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL fetch px%0d wait%0d: req=%b addr=%0d eval=%b busy=%b done=%b, required req=1 addr=%0d eval=0 busy=1 done=0",
                             i, k, fetch_req, fetch_addr, eval, busy, done, exp_addr[i]);
                end
                fetch_ack = (k == d);
                if (rnd_ctl) begin
                    start     = 1'($urandom);
                    thres_in  = 8'($urandom);
                    is_corner = 1'($urandom);
                end
                step();
            end
            fetch_ack = rnd_ctl ? 1'($urandom) : 1'b0;
            c = (cmode == 0) ? 1'b0 : (cmode == 1) ? 1'(i == 1 || i == 3) : 1'($urandom);
            is_corner = c;
            if (c) cnt++;
            checks++;
            if ({eval, ref_addr, fetch_req, busy, done, thres} !== {1'b1, AW'(exp_addr[i]), 1'b0, 1'b1, 1'b0, t}) begin
                errors++;
                $display("FAIL eval px%0d: eval=%b ref=%0d req=%b busy=%b done=%b thres=%h, required eval=1 ref=%0d req=0 busy=1 done=0 thres=%h",
                         i, eval, ref_addr, fetch_req, busy, done, thres, exp_addr[i], t);
            end
            step();
            fetch_ack = 1'b0;
            is_corner = rnd_ctl ? 1'($urandom) : 1'b0;
        end
        start = 1'b0;
        is_corner = 1'b0;
        checks++;
        if ({done, busy, eval, fetch_req, corner_cnt} !== {4'b1000, 16'(cnt)}) begin
            errors++;
            $display("FAIL done: done=%b busy=%b eval=%b req=%b cnt=%0d, required done=1 busy=0 eval=0 req=0 cnt=%0d",
                     done, busy, eval, fetch_req, corner_cnt, cnt);
        end
        step();
        checks++;
        if ({done, busy, eval, fetch_req, corner_cnt, thres} !== {4'b0000, 16'(cnt), t}) begin
            errors++;
            $display("FAIL idle_after_done: done=%b busy=%b eval=%b req=%b cnt=%0d thres=%h, required 0 0 0 0 cnt=%0d thres=%h",
                     done, busy, eval, fetch_req, corner_cnt, thres, cnt, t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; thres_in = 8'hA5;
        fetch_ack = 1'b0; is_corner = 1'b0;
        step(); step();
        checks++;
        if ({fetch_req, fetch_addr, eval, ref_addr, thres, busy, done, corner_cnt} !== '0) begin
            errors++;
            $display("FAIL reset: req=%b faddr=%0d eval=%b raddr=%0d thres=%h busy=%b done=%b cnt=%0d, required all 0",
                     fetch_req, fetch_addr, eval, ref_addr, thres, busy, done, corner_cnt);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_abort();
        thres_in = 8'h33;
        start = 1'b1;
        step();
        start = 1'b0;
        skip_clear();
        // pixel 27 without corner, pixel 28 with corner
        for (int p = 0; p < 2; p++) begin
            fetch_ack = 1'b1;
            step();
            fetch_ack = 1'b0;
            is_corner = 1'(p);
            step();
            is_corner = 1'b0;
        end
        checks++;
        if ({fetch_req, fetch_addr} !== {1'b1, AW'(35)}) begin
            errors++;
            $display("FAIL abort_pre: req=%b addr=%0d, required req=1 addr=35", fetch_req, fetch_addr);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy, fetch_req, eval, done, corner_cnt} !== {4'b0000, 16'd1}) begin
                errors++;
                $display("FAIL abort[%0d]: busy=%b req=%b eval=%b done=%b cnt=%0d, required 0 0 0 0 cnt=1",
                         k, busy, fetch_req, eval, done, corner_cnt);
            end
            step();
        end
        // start and abort together in IDLE: the start must be taken
        abort = 1'b1;
        run_frame(8'h3C, 2, 2, 1'b0);
    endtask

    task automatic test_degenerate();
        thres_in = 8'h11;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({d_done, d_busy, d_fetch_req, d_eval, d_corner_cnt} !== {4'b1000, 16'd0}) begin
            errors++;
            $display("FAIL degenerate_done: done=%b busy=%b req=%b eval=%b cnt=%0d, required 1 0 0 0 cnt=0",
                     d_done, d_busy, d_fetch_req, d_eval, d_corner_cnt);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({d_done, d_busy, busy, fetch_req} !== 4'b0000) begin
            errors++;
            $display("FAIL degenerate_after: d_done=%b d_busy=%b busy=%b req=%b, required all 0",
                     d_done, d_busy, busy, fetch_req);
        end
        step();
    endtask

    task automatic test_async_reset();
        thres_in = 8'h77;
        start = 1'b1;
        step();
        start = 1'b0;
        skip_clear();
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        is_corner = 1'b1;
        step();
        is_corner = 1'b0;
        step();
        // mid-FETCH of the second pixel, between clock edges
        reset = 1'b1;
        #2;
        checks++;
        if ({fetch_req, fetch_addr, eval, ref_addr, thres, busy, done, corner_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: req=%b faddr=%0d eval=%b thres=%h busy=%b done=%b cnt=%0d, required all 0",
                     fetch_req, fetch_addr, eval, thres, busy, done, corner_cnt);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_model();
        test_reset();
        run_frame(8'h14, 0, 0, 1'b0);   // ack tied high, no corners
        run_frame(8'h14, 0, 1, 1'b0);   // corners on evals 2 and 4
        run_frame(8'h14, 3, 1, 1'b0);   // delayed acks
        test_abort();
        test_degenerate();
        test_async_reset();
        for (int f = 0; f < 6; f++)
            run_frame(8'($urandom), 4, 2, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
